// File: rtl/fp_unit_issuer_if.sv
// Request, unit and result signals of the val/done floating-point unit issuer.
// Handshake: in_* and out_* transfer on the rising edge where valid & ready are both high;
// ready never depends on valid, and valid/data must hold until that edge. unit_val is a
// one-cycle issue pulse; each cycle of unit_done high returns one result.
interface fp_unit_issuer_if #(
  parameter int WIDTH = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_rm;
  logic             unit_val;
  logic [WIDTH-1:0] unit_a;
  logic [WIDTH-1:0] unit_b;
  logic [2:0]       unit_rm;
  logic [WIDTH-1:0] unit_out;
  logic [4:0]       unit_flags;
  logic             unit_done;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [4:0]       out_flags;
  logic [4:0]       in_flight;
  logic             busy;
  logic             err;

  modport master (
    input  in_valid, in_a, in_b, in_rm, unit_out, unit_flags, unit_done, out_ready,
    output in_ready, unit_val, unit_a, unit_b, unit_rm, out_valid, out_data, out_flags,
           in_flight, busy, err
  );

  modport slave (
    output in_valid, in_a, in_b, in_rm, unit_out, unit_flags, unit_done, out_ready,
    input  in_ready, unit_val, unit_a, unit_b, unit_rm, out_valid, out_data, out_flags,
           in_flight, busy, err
  );
endinterface

// File: rtl/fp_unit_issuer.sv
// Issues operand requests to a fixed-latency val/done unit with a minimum spacing and
// collects results into a FIFO; credits reserve a FIFO slot for every op in flight.
module fp_unit_issuer #(
  parameter int WIDTH      = 6,
  parameter int LATENCY    = 4,
  parameter int MIN_GAP    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             reset,
  fp_unit_issuer_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + 5;

  generate
    if (LATENCY < 1 || LATENCY > 15 || MIN_GAP < 1 || MIN_GAP > 15 ||
        FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
      $error("fp_unit_issuer: parameter out of range");
    end
  endgenerate

  logic             r_unit_val;
  logic [WIDTH-1:0] r_unit_a;
  logic [WIDTH-1:0] r_unit_b;
  logic [2:0]       r_unit_rm;
  logic [4:0]       r_in_flight;
  logic [3:0]       r_gap_cnt;
  logic             r_err;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [EW-1:0]    r_mem [FIFO_DEPTH];

  logic [5:0]    w_occupancy;
  logic          w_credit_ok;
  logic          w_gap_ok;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_spurious;
  logic          w_done_ok;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_out_valid;
  logic [EW-1:0] w_head;

  // Only registered state feeds in_ready: a slot freed by a pop this cycle is usable next cycle.
  assign w_occupancy = {1'b0, r_in_flight} + 6'(r_count);
  assign w_credit_ok = w_occupancy < 6'(FIFO_DEPTH);
  assign w_gap_ok    = (r_gap_cnt == 4'd0);
  assign w_in_ready  = !reset && w_credit_ok && w_gap_ok;
  assign w_accept    = bus.in_valid && w_in_ready;

  assign w_spurious  = bus.unit_done && (r_in_flight == 5'd0);
  assign w_done_ok   = bus.unit_done && (r_in_flight != 5'd0);
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_push      = w_done_ok && !w_full;
  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_head      = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_unit_val  <= 1'b0;
      r_unit_a    <= '0;
      r_unit_b    <= '0;
      r_unit_rm   <= '0;
      r_in_flight <= '0;
      r_gap_cnt   <= '0;
      r_err       <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_unit_val <= w_accept;
      if (w_accept) begin
        r_unit_a  <= bus.in_a;
        r_unit_b  <= bus.in_b;
        r_unit_rm <= bus.in_rm;
        r_gap_cnt <= 4'(MIN_GAP - 1);
      end else if (r_gap_cnt != 4'd0) begin
        r_gap_cnt <= r_gap_cnt - 4'd1;
      end

      case ({w_accept, w_done_ok})
        2'b10:   r_in_flight <= r_in_flight + 5'd1;
        2'b01:   r_in_flight <= r_in_flight - 5'd1;
        default: r_in_flight <= r_in_flight;
      endcase

      if (w_push) begin
        r_mem[r_wr_ptr] <= {bus.unit_flags, bus.unit_out};
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      // A completion that finds the FIFO full means the credit logic was violated.
      if (w_spurious || (w_done_ok && w_full)) r_err <= 1'b1;
    end
  end

  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (reset) !(w_done_ok && w_full));

  assign bus.in_ready  = w_in_ready;
  assign bus.unit_val  = r_unit_val;
  assign bus.unit_a    = r_unit_a;
  assign bus.unit_b    = r_unit_b;
  assign bus.unit_rm   = r_unit_rm;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_head[WIDTH-1:0];
  assign bus.out_flags = w_head[EW-1:WIDTH];
  assign bus.in_flight = r_in_flight;
  assign bus.busy      = (r_in_flight != 5'd0) || w_out_valid;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_fp_unit_issuer.sv
// Bench for fp_unit_issuer: fixed-latency adder unit model, scoreboard queue on the result
// stream, a vector table for the main path and directed sequences for stalls and resets.
module tb_fp_unit_issuer;
  localparam int WIDTH      = 6;
  localparam int LATENCY    = 4;
  localparam int MIN_GAP    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int EW         = WIDTH + 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fp_unit_issuer_if #(.WIDTH(WIDTH)) bus ();

  fp_unit_issuer #(
    .WIDTH(WIDTH), .LATENCY(LATENCY), .MIN_GAP(MIN_GAP), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // ---------------- unit model: result = a+b, flags = a[4:0] ----------------
  logic [LATENCY-1:0] u_vsr;
  logic [EW-1:0]      u_rsr [LATENCY];
  logic               spur_done = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      u_vsr <= '0;
      for (int i = 0; i < LATENCY; i++) u_rsr[i] <= '0;
    end else begin
      u_vsr[0] <= bus.unit_val;
      u_rsr[0] <= {bus.unit_a[4:0], bus.unit_a + bus.unit_b};
      for (int i = 1; i < LATENCY; i++) begin
        u_vsr[i] <= u_vsr[i-1];
        u_rsr[i] <= u_rsr[i-1];
      end
    end
  end

  assign bus.unit_done  = u_vsr[LATENCY-1] | spur_done;
  assign bus.unit_out   = u_rsr[LATENCY-1][WIDTH-1:0];
  assign bus.unit_flags = u_rsr[LATENCY-1][EW-1:WIDTH];

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("out_data", 32'(bus.out_data), 32'(e[WIDTH-1:0]));
        check("out_flags", 32'(bus.out_flags), 32'(e[EW-1:WIDTH]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] s;
    s = a + b;
    return {a[4:0], s};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge, in_valid left high.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] rm,
                      input logic [EW-1:0] exp, output int stalls);
    bit ok;
    ok = 1'b0;
    stalls = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_rm = rm;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      stalls++;
    end
    check("send_accepted", 32'(ok), 32'd1);
    if (ok) exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic send_m(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] rm,
                        output int stalls);
    send(a, b, rm, model(a, b), stalls);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick(1);
      if (!bus.busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_done", 32'(ok), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       rm;
    logic [WIDTH-1:0] d;
    logic [4:0]       f;
  } vec_t;
  vec_t tbl [8];

  bit rnd_done;

  initial begin
    int st, k, seen;
    bit ok;
    logic [WIDTH-1:0] ra, rb;

    tbl[0] = '{6'h01, 6'h02, 3'd0, 6'h03, 5'h01};
    tbl[1] = '{6'h03, 6'h04, 3'd1, 6'h07, 5'h03};
    tbl[2] = '{6'h05, 6'h06, 3'd2, 6'h0B, 5'h05};
    tbl[3] = '{6'h07, 6'h08, 3'd3, 6'h0F, 5'h07};
    tbl[4] = '{6'h3F, 6'h01, 3'd4, 6'h00, 5'h1F};
    tbl[5] = '{6'h20, 6'h20, 3'd5, 6'h00, 5'h00};
    tbl[6] = '{6'h2A, 6'h15, 3'd6, 6'h3F, 5'h0A};
    tbl[7] = '{6'h3F, 6'h3F, 3'd7, 6'h3E, 5'h1F};

    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_rm = '0;
    bus.out_ready = 1'b0;

    // reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_unit_val", 32'(bus.unit_val), 32'd0);
    check("rst_unit_a", 32'(bus.unit_a), 32'd0);
    check("rst_unit_b", 32'(bus.unit_b), 32'd0);
    check("rst_unit_rm", 32'(bus.unit_rm), 32'd0);
    check("rst_in_flight", 32'(bus.in_flight), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_flags", 32'(bus.out_flags), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    reset = 1'b0;

    // single op and latency
    bus.out_ready = 1'b1;
    send(6'h05, 6'h03, 3'd2, {5'h05, 6'h08}, st);
    bus.in_valid = 1'b0;
    check("single_unit_val", 32'(bus.unit_val), 32'd1);
    check("single_unit_a", 32'(bus.unit_a), 32'h05);
    check("single_unit_b", 32'(bus.unit_b), 32'h03);
    check("single_unit_rm", 32'(bus.unit_rm), 32'd2);
    check("single_in_flight1", 32'(bus.in_flight), 32'd1);
    k = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      k++;
      if (k == 1) check("single_val_pulse", 32'(bus.unit_val), 32'd0);
      if (bus.out_valid) break;
    end
    check("single_latency", 32'(k), 32'(LATENCY + 1));
    check("single_in_flight0", 32'(bus.in_flight), 32'd0);
    tick(1);
    check("single_popped", 32'(bus.out_valid), 32'd0);
    check("single_busy", 32'(bus.busy), 32'd0);

    // table-driven back-to-back issue with in_valid held high
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].rm, {tbl[i].f, tbl[i].d}, st);
      check("tbl_gap_stall", 32'(st), 32'((i == 0) ? 0 : MIN_GAP - 1));
      check("tbl_unit_a", 32'(bus.unit_a), 32'(tbl[i].a));
      check("tbl_unit_rm", 32'(bus.unit_rm), 32'(tbl[i].rm));
    end
    bus.in_valid = 1'b0;
    wait_drain();

    // stalled consumer: credits cap acceptance at FIFO_DEPTH
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_m(6'(i * 5 + 1), 6'(i + 9), 3'd1, st);
    bus.in_a = 6'h21;
    bus.in_b = 6'h02;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.in_ready) seen++;
    end
    tick(1);
    check("stall_ready_low", 32'(seen), 32'd0);
    check("stall_in_flight", 32'(bus.in_flight), 32'd0);
    check("stall_out_valid", 32'(bus.out_valid), 32'd1);
    check("stall_err", 32'(bus.err), 32'd0);
    bus.out_ready = 1'b1;
    send_m(6'h21, 6'h02, 3'd2, st);
    check("stall_release", 32'(st), 32'd1);
    send_m(6'h30, 6'h11, 3'd3, st);
    bus.in_valid = 1'b0;
    wait_drain();

    // completion and pop on the same edge with two entries queued
    bus.out_ready = 1'b0;
    send_m(6'h0A, 6'h01, 3'd0, st);
    send_m(6'h0B, 6'h02, 3'd0, st);
    bus.in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (bus.in_flight == 5'd0) begin
        ok = 1'b1;
        break;
      end
    end
    check("pp_two_queued", 32'(ok), 32'd1);
    send_m(6'h0C, 6'h03, 3'd0, st);
    bus.in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.unit_done) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check("pp_done_seen", 32'(ok), 32'd1);
    bus.out_ready = 1'b1;
    tick(1);
    check("pp_count2_valid", 32'(bus.out_valid), 32'd1);
    check("pp_in_flight", 32'(bus.in_flight), 32'd0);
    tick(1);
    check("pp_count1_valid", 32'(bus.out_valid), 32'd1);
    tick(1);
    check("pp_count0_valid", 32'(bus.out_valid), 32'd0);

    // random ops with a random consumer: pointers wrap several times
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          ra = 6'($urandom_range(0, 63));
          rb = 6'($urandom_range(0, 63));
          send_m(ra, rb, 3'(i), st);
        end
        bus.in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_drain();

    // spurious unit_done with nothing in flight
    check("spur_err_before", 32'(bus.err), 32'd0);
    spur_done = 1'b1;
    tick(1);
    spur_done = 1'b0;
    check("spur_no_push", 32'(bus.out_valid), 32'd0);
    check("spur_in_flight", 32'(bus.in_flight), 32'd0);
    check("spur_err", 32'(bus.err), 32'd1);
    tick(5);
    check("spur_err_sticky", 32'(bus.err), 32'd1);
    check("spur_busy", 32'(bus.busy), 32'd0);

    // reset with two in flight and one queued
    bus.out_ready = 1'b0;
    send_m(6'h01, 6'h01, 3'd0, st);
    bus.in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("mid_first_queued", 32'(ok), 32'd1);
    send_m(6'h02, 6'h02, 3'd0, st);
    send_m(6'h03, 6'h03, 3'd0, st);
    bus.in_valid = 1'b0;
    check("mid_in_flight2", 32'(bus.in_flight), 32'd2);
    check("mid_queued", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    tick(1);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_in_flight", 32'(bus.in_flight), 32'd0);
    check("mid_rst_err", 32'(bus.err), 32'd0);
    check("mid_rst_unit_val", 32'(bus.unit_val), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    bus.out_ready = 1'b1;
    send(6'h11, 6'h22, 3'd4, {5'h11, 6'h33}, st);
    bus.in_valid = 1'b0;
    wait_drain();

    check("sb_empty_at_end", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fp_unit_issuer.md
Name: fp_unit_issuer

Overview:
- Initiator/collector for the fixed-latency floating-point units that use a val/done handshake (mulFN and siblings).
- Accepts operand requests on a ready/valid stream and drives unit_val/operands with a minimum issue spacing.
- Captures each result when unit_done rises, queues {flags, result} in a result FIFO, and presents them on a ready/valid output stream.
- Credit accounting guarantees no result is ever lost when the downstream consumer stalls.

Parameters:
- WIDTH, 6, operand/result width (expWidth + sigWidth of the attached unit).
- LATENCY, 4, cycles from the unit sampling unit_val=1 to unit_done=1; range 1..15.
- MIN_GAP, 2, minimum cycles between consecutive unit_val pulses; range 1..15.
- FIFO_DEPTH, 4, result FIFO entries; power of two, range 2..16.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted on edge where in_valid & in_ready.
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- in_rm  in  3  rounding mode.
- unit_val  out  1  one-cycle issue pulse to unit.
- unit_a  out  WIDTH  registered operand a.
- unit_b  out  WIDTH  registered operand b.
- unit_rm  out  3  registered rounding mode.
- unit_out  in  WIDTH  unit result.
- unit_flags  in  5  unit exception flags.
- unit_done  in  1  unit result valid.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result when out_valid & out_ready.
- out_data  out  WIDTH  FIFO head result.
- out_flags  out  5  FIFO head flags.
- in_flight  out  5  ops issued, not yet completed.
- busy  out  1  in_flight != 0 or FIFO non-empty.
- err  out  1  sticky: unit_done seen with in_flight == 0.

Behaviour:
- Reset values (edge with reset=1): unit_val=0, unit_a/unit_b/unit_rm=0, in_flight=0, FIFO empty (out_valid=0; out_data/out_flags=0), gap counter=0, err=0, busy=0. in_ready=0 while reset is high.
- Reset mid-operation: all in-flight accounting and queued results are discarded. The attached unit shares the reset.
- Credit rule: credit_ok = (in_flight + fifo_count) < FIFO_DEPTH, computed from registered values only. No same-cycle bypass from pops or completions.
- Gap rule: gap_cnt is loaded with MIN_GAP-1 on issue and decrements to 0; gap_ok = (gap_cnt == 0).
- in_ready = !reset & credit_ok & gap_ok. Combinational from registers only; never depends on in_valid.
- Issue: on an accepting edge, unit_a/unit_b/unit_rm <= in_a/in_b/in_rm and unit_val <= 1 for exactly one cycle. Operand registers then hold their value until the next issue.
- Completion: on an edge with unit_done=1 and in_flight>0, push {unit_flags, unit_out} into the FIFO and decrement in_flight.
  - If in_flight==0, do not push, leave in_flight at 0, and set err.
  - unit_done high for k consecutive cycles counts as k completions.
- Simultaneous issue and completion: in_flight unchanged. Simultaneous push and pop: fifo_count unchanged, both performed.
- The FIFO cannot overflow by construction. A push into a full FIFO is a design error: assert in simulation, drop the push, set err.
- FIFO: circular buffer with wrap-around pointers of log2(FIFO_DEPTH) bits plus a count. out_data/out_flags show the head entry combinationally from storage.
- Latency with an empty pipe:
  - Request accepted at edge E0.
  - unit_val high in the cycle after E0; the unit samples it at E1.
  - unit_done high after E1+LATENCY−1.
  - Result captured at edge E1+LATENCY; out_valid high in the following cycle, i.e. LATENCY+1 edges after E0.
- Throughput: one issue per MIN_GAP cycles while credits are available.
- Ordering: results leave in issue order.
- busy = (in_flight != 0) | out_valid.

Test Plan:
- Bench unit model: fixed latency LATENCY, result = (a+b) mod 2^WIDTH, flags = a[4:0]. Latency drives unit_done only; unit_out and unit_flags are computed from the unit's registered operands.
- Single op: after reset, a=6'h05, b=6'h03 accepted at edge 0, out_ready=1 → unit_val one cycle; out_valid at edge 5 with out_data=6'h08, out_flags=5'h05; in_flight 1→0; busy falls after pop.
- Back-to-back with in_valid held high for 4 requests (1,2),(3,4),(5,6),(7,8) → in_ready low 1 of every 2 cycles (MIN_GAP=2); outputs 3,7,11,15 in order.
- Stalled consumer: out_ready=0 with 6 requests offered → exactly 4 accepted; in_ready stays 0; FIFO full; no err. Releasing out_ready → 4 results drain in order, then the remaining 2 are accepted.
- Simultaneous pop and completion with the FIFO holding 2 entries → count stays 2, order preserved, pointers wrap correctly over 10 ops.
- Spurious unit_done=1 with in_flight=0 → no push, out_valid stays 0, err=1 and stays 1 until reset.
- Reset asserted with 2 in flight and 1 queued → next cycle: out_valid=0, in_flight=0, err=0, unit_val=0; a new op then completes with the correct value.
